uart_srfifo: RTL and testbench

UART_SRFIFO -- requirements
Module: uart_srfifo

---
 rtl/uart_srfifo_pkg.sv | 15 +
 rtl/uart_srfifo_vtdl.sv | 27 ++
 rtl/uart_srfifo.sv | 148 ++++++++++++++
 tb/tb_uart_srfifo.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_srfifo_pkg.sv
// Shared types and helpers for the uart_srfifo shift-register FIFO.
package uart_srfifo_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      PART  = 2'd1,
      FULL  = 2'd2
   } occ_state_t;

   // Occupancy counter width: must be able to hold the value DEP itself.
   function automatic int cnt_width(input int dep);
      return $clog2(dep) + 1;
   endfunction

endpackage

// File: rtl/uart_srfifo_vtdl.sv
// Variable-tap delay line: shift register written at slot 0, read at slot a.
module vtdl #(
   parameter int WID = 8,
   parameter int DEP = 16
) (
   input  logic                    clk,
   input  logic                    ce,
   input  logic [$clog2(DEP)-1:0]  a,
   input  logic [WID-1:0]          d,
   output logic [WID-1:0]          q
);

   logic [WID-1:0] sr_r [DEP];

   // Storage shift; deliberately unreset because the tap is gated by occupancy.
   always_ff @(posedge clk) begin
      if (ce) begin
         sr_r[0] <= d;
         for (int i = 1; i < DEP; i++) begin
            sr_r[i] <= sr_r[i-1];
         end
      end
   end

   assign q = sr_r[a];

endmodule

// File: rtl/uart_srfifo.sv
// Shift-register FIFO with occupancy FSM, sticky overflow/underflow flags.
// Define UART_SRFIFO_OREG_EN for a registered dout (1-cycle read latency).
module uart_srfifo
   import uart_srfifo_pkg::*;
#(
   parameter int WID    = 8,
   parameter int DEP    = 16,
   parameter int AF_LVL = DEP - 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        wr,
   input  logic [WID-1:0]              din,
   input  logic                        rd,
   output logic [WID-1:0]              dout,
   output logic [cnt_width(DEP)-1:0]   cnt,
   output logic                        empty,
   output logic                        full,
   output logic                        afull,
   output logic                        ovr,
   output logic                        unf
);

   localparam int AW = $clog2(DEP);
   localparam int CW = cnt_width(DEP);
   localparam logic [CW-1:0] DEP_C  = CW'(DEP);
   localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] ZERO_C = CW'(0);

   occ_state_t      state_r, state_nxt_s;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic            ovr_r, ovr_nxt_s;
   logic            unf_r, unf_nxt_s;
   logic            afull_r, afull_nxt_s;
   logic            wr_acc_s, rd_acc_s;
   logic [AW-1:0]   addr_s;
   logic [WID-1:0]  tap_s;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign wr_acc_s = wr & ~clr & ((state_r != FULL) | rd);
   assign rd_acc_s = rd & ~clr & (state_r != EMPTY);

   // Tap address points at the oldest entry; held at 0 when nothing is stored.
   always_comb begin
      addr_s = '0;
      if (state_r == EMPTY) begin
         addr_s = '0;
      end else begin
         addr_s = AW'(cnt_r - ONE_C);
      end
   end

   // Next occupancy, flags and state.
   always_comb begin
      cnt_nxt_s   = cnt_r;
      ovr_nxt_s   = ovr_r;
      unf_nxt_s   = unf_r;
      afull_nxt_s = afull_r;
      state_nxt_s = state_r;
      if (clr) begin
         cnt_nxt_s   = ZERO_C;
         ovr_nxt_s   = 1'b0;
         unf_nxt_s   = 1'b0;
         afull_nxt_s = 1'b0;
      end else begin
         case ({wr_acc_s, rd_acc_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - ONE_C;
            default: cnt_nxt_s = cnt_r;
         endcase
         if (wr && !rd && (state_r == FULL)) begin
            ovr_nxt_s = 1'b1;
         end else begin
            ovr_nxt_s = ovr_r;
         end
         if (rd && (state_r == EMPTY)) begin
            unf_nxt_s = 1'b1;
         end else begin
            unf_nxt_s = unf_r;
         end
         afull_nxt_s = (cnt_nxt_s >= AF_C);
      end
      if (cnt_nxt_s == ZERO_C) begin
         state_nxt_s = EMPTY;
      end else if (cnt_nxt_s == DEP_C) begin
         state_nxt_s = FULL;
      end else begin
         state_nxt_s = PART;
      end
   end

   // Occupancy state, counter and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= EMPTY;
         cnt_r   <= ZERO_C;
         ovr_r   <= 1'b0;
         unf_r   <= 1'b0;
         afull_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ovr_r   <= ovr_nxt_s;
         unf_r   <= unf_nxt_s;
         afull_r <= afull_nxt_s;
      end
   end

   vtdl #(
      .WID (WID),
      .DEP (DEP)
   ) u_vtdl (
      .clk (clk),
      .ce  (wr_acc_s),
      .a   (addr_s),
      .d   (din),
      .q   (tap_s)
   );

`ifdef UART_SRFIFO_OREG_EN
   logic [WID-1:0] dout_r;

   // Output register captures the entry being popped and holds it otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r <= '0;
      end else if (rd_acc_s) begin
         dout_r <= tap_s;
      end else begin
         dout_r <= dout_r;
      end
   end

   assign dout = dout_r;
`else
   assign dout = tap_s;
`endif

   assign cnt   = cnt_r;
   assign empty = (state_r == EMPTY);
   assign full  = (state_r == FULL);
   assign afull = afull_r;
   assign ovr   = ovr_r;
   assign unf   = unf_r;

endmodule

// File: tb/tb_uart_srfifo.sv
// Directed self-checking bench for uart_srfifo (WID=8, DEP=16, AF_LVL=14).
module tb_uart_srfifo;

   logic       clk = 1'b0;
   logic       rst_n, clr, wr, rd;
   logic [7:0] din, dout;
   logic [4:0] cnt;
   logic       empty, full, afull, ovr, unf;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   uart_srfifo #(.WID(8), .DEP(16), .AF_LVL(14)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .din(din), .rd(rd),
      .dout(dout), .cnt(cnt), .empty(empty), .full(full), .afull(afull),
      .ovr(ovr), .unf(unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Status vector {cnt, empty, full, afull, ovr, unf}; afull expected from cnt.
   task automatic stat(input string tag, input int ec, input logic eo, input logic eu);
      chk(tag, {22'd0, cnt, empty, full, afull, ovr, unf},
          {22'd0, 5'(ec), 1'(ec == 0), 1'(ec == 16), 1'(ec >= 14), eo, eu});
   endtask

   // One clock cycle; optionally checks the popped data at the mode's latency.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c,
                      input bit pchk, input logic [7:0] pexp, input string tag);
      wr = w; din = d; rd = r; clr = c;
`ifndef UART_SRFIFO_OREG_EN
      #1;
      if (pchk) chk(tag, {24'd0, dout}, {24'd0, pexp});
`endif
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
`ifdef UART_SRFIFO_OREG_EN
      if (pchk) chk(tag, {24'd0, dout}, {24'd0, pexp});
`endif
   endtask

   task automatic fill(input logic [7:0] base, input int n, input int c0,
                       input logic eo, input logic eu);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, "fill");
         stat("fill_st", c0 + i + 1, eo, eu);
      end
   endtask

   task automatic drain(input logic [7:0] base, input int n, input int c0,
                        input logic eo, input logic eu);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, base + 8'(i), "drain_data");
         stat("drain_st", c0 - i - 1, eo, eu);
      end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      stat("reset", 0, 1'b0, 1'b0);
`ifdef UART_SRFIFO_OREG_EN
      chk("reset_dout", {24'd0, dout}, 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full, then drain in order.
      fill(8'h01, 16, 0, 1'b0, 1'b0);
      drain(8'h01, 16, 16, 1'b0, 1'b0);

      // Overflow: write in FULL is dropped, 0xAA never appears.
      fill(8'h01, 16, 0, 1'b0, 1'b0);
      cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, "ovr_wr");
      stat("ovr_st", 16, 1'b1, 1'b0);
      drain(8'h01, 16, 16, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, "clr");
      stat("clr_ovr", 0, 1'b0, 1'b0);

      // Simultaneous read/write while FULL.
      fill(8'h21, 16, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h21 + 8'(i), "rw_full_data");
         stat("rw_full_st", 16, 1'b0, 1'b0);
      end
      drain(8'h25, 12, 16, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, "rw_full_tail");
         stat("rw_full_tail_st", 3 - i, 1'b0, 1'b0);
      end

      // Simultaneous read/write while EMPTY: write only, underflow flagged.
      cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, "rw_empty");
      stat("rw_empty_st", 1, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, "rw_empty_data");
      stat("rw_empty_after", 0, 1'b0, 1'b1);

      // Asynchronous reset between edges with five entries stored.
      fill(8'h61, 5, 0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      stat("async_rst", 0, 1'b0, 1'b0);
`ifdef UART_SRFIFO_OREG_EN
      chk("async_rst_dout", {24'd0, dout}, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, "post_rst_wr");
      stat("post_rst_st", 1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, "post_rst_data");
      stat("post_rst_empty", 0, 1'b0, 1'b0);

      // clr wins over a same-cycle write with seven entries stored.
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, "unf_set");
      stat("unf_set_st", 0, 1'b0, 1'b1);
      fill(8'h81, 7, 0, 1'b0, 1'b1);
      cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00, "clr_wr");
      stat("clr_wr_st", 0, 1'b0, 1'b0);
      cyc(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00, "after_clr_wr");
      stat("after_clr_st", 1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, "after_clr_data");
      stat("after_clr_empty", 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
